// File: rtl/w5300_init_seq_if.sv
// rtl/w5300_init_seq_if.sv - single-transaction handshake between the init sequencer and the W5300 rw engine
interface w5300_init_seq_if;
    logic        req;
    logic        wr;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;

    modport master (
        output req,
        output wr,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  wr,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/w5300_init_seq.sv
// rtl/w5300_init_seq.sv - W5300 power-up reset, PLL-lock wait, register programming and IP read-back check
module w5300_init_seq #(
    parameter int          CLK_FREQ    = 100,
    parameter int          RST_LOW_US  = 2,
    parameter int          LOCK_US     = 10000,
    parameter int          ACK_TIMEOUT = 1024,
    parameter logic [47:0] MAC         = 48'h00_08_DC_01_02_03,
    parameter logic [31:0] GATEWAY     = 32'hC0A8_0101,
    parameter logic [31:0] SUBNET      = 32'hFFFF_FF00,
    parameter logic [31:0] IP          = 32'hC0A8_0164
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    chip_rst_n,
    w5300_init_seq_if.master        bus,
    output logic                    ready,
    output logic                    err,
    output logic [1:0]              err_code
);

    typedef enum logic [2:0] {
        S_RST_LOW,
        S_LOCK_WAIT,
        S_ISSUE,
        S_WAIT_ACK,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [23:0] RST_CYC   = 24'(CLK_FREQ * RST_LOW_US);
    localparam logic [23:0] LOCK_CYC  = 24'(CLK_FREQ * LOCK_US);
    localparam logic [23:0] TO_CYC    = 24'(ACK_TIMEOUT);
    localparam logic [3:0]  LAST_STEP = 4'd12;

    localparam logic [1:0] ERR_BUS_WIDTH = 2'd1;
    localparam logic [1:0] ERR_READBACK  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

    // Returns {wr, addr, wdata} for one step of the configuration program.
    function automatic logic [26:0] step_rom(input logic [3:0] idx);
        logic [26:0] s;
        case (idx)
            4'd0:    s = {1'b0, 10'h000, 16'h0000};
            4'd1:    s = {1'b1, 10'h004, 16'h0000};
            4'd2:    s = {1'b1, 10'h008, MAC[47:32]};
            4'd3:    s = {1'b1, 10'h00A, MAC[31:16]};
            4'd4:    s = {1'b1, 10'h00C, MAC[15:0]};
            4'd5:    s = {1'b1, 10'h010, GATEWAY[31:16]};
            4'd6:    s = {1'b1, 10'h012, GATEWAY[15:0]};
            4'd7:    s = {1'b1, 10'h014, SUBNET[31:16]};
            4'd8:    s = {1'b1, 10'h016, SUBNET[15:0]};
            4'd9:    s = {1'b1, 10'h018, IP[31:16]};
            4'd10:   s = {1'b1, 10'h01A, IP[15:0]};
            4'd11:   s = {1'b0, 10'h018, 16'h0000};
            4'd12:   s = {1'b0, 10'h01A, 16'h0000};
            default: s = 27'd0;
        endcase
        return s;
    endfunction

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  step_q, step_d;
    logic        chip_rst_n_q, chip_rst_n_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic [9:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_d       = step_q;
        chip_rst_n_d = chip_rst_n_q;
        req_d        = req_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ready_d      = ready_q;
        err_d        = err_q;
        err_code_d   = err_code_q;

        case (state_q)
            S_RST_LOW: begin
                chip_rst_n_d = 1'b0;
                if (cnt_q == RST_CYC - 24'd1) begin
                    state_d      = S_LOCK_WAIT;
                    cnt_d        = 24'd0;
                    chip_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_LOCK_WAIT: begin
                if (cnt_q == LOCK_CYC - 24'd1) begin
                    state_d = S_ISSUE;
                    cnt_d   = 24'd0;
                    step_d  = 4'd0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_ISSUE: begin
                {wr_d, addr_d, wdata_d} = step_rom(step_q);
                req_d   = 1'b1;
                cnt_d   = 24'd0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // An ack in the timeout cycle itself still completes the step.
                if (bus.ack) begin
                    req_d = 1'b0;
                    if (step_q == 4'd0 && !bus.rdata[15]) begin
                        state_d    = S_FAULT;
                        err_d      = 1'b1;
                        err_code_d = ERR_BUS_WIDTH;
                    end else if ((step_q == 4'd11 && bus.rdata != IP[31:16]) ||
                                 (step_q == 4'd12 && bus.rdata != IP[15:0])) begin
                        state_d    = S_FAULT;
                        err_d      = 1'b1;
                        err_code_d = ERR_READBACK;
                    end else if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                        ready_d = 1'b1;
                    end else begin
                        step_d  = step_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end else if (cnt_q == TO_CYC - 24'd1) begin
                    req_d      = 1'b0;
                    state_d    = S_FAULT;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_DONE, S_FAULT: begin
                if (start) begin
                    state_d      = S_RST_LOW;
                    cnt_d        = 24'd0;
                    step_d       = 4'd0;
                    chip_rst_n_d = 1'b0;
                    ready_d      = 1'b0;
                    err_d        = 1'b0;
                    err_code_d   = 2'd0;
                end
            end
            default: state_d = S_RST_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RST_LOW;
            cnt_q        <= 24'd0;
            step_q       <= 4'd0;
            chip_rst_n_q <= 1'b0;
            req_q        <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= 10'd0;
            wdata_q      <= 16'd0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            chip_rst_n_q <= chip_rst_n_d;
            req_q        <= req_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign chip_rst_n = chip_rst_n_q;
    assign bus.req    = req_q;
    assign bus.wr     = wr_q;
    assign bus.addr   = addr_q;
    assign bus.wdata  = wdata_q;
    assign ready      = ready_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_w5300_init_seq.sv
// tb/tb_w5300_init_seq.sv - directed bench for w5300_init_seq with a small rw-engine model
module tb_w5300_init_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       chip_rst_n;
    logic       ready;
    logic       err;
    logic [1:0] err_code;

    w5300_init_seq_if bus_if ();

    w5300_init_seq #(
        .CLK_FREQ    (1),
        .RST_LOW_US  (4),
        .LOCK_US     (8),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .chip_rst_n (chip_rst_n),
        .bus        (bus_if.master),
        .ready      (ready),
        .err        (err),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // rw-engine model: acks 3 cycles after req rises, echoes a small register file
    logic [15:0] mem [0:511];
    logic [15:0] mr_val;
    logic        corrupt;
    logic        withhold;
    int          hold_idx;
    int          wcnt;
    int          n_tx;
    logic        log_wr    [0:15];
    logic [9:0]  log_addr  [0:15];
    logic [15:0] log_wdata [0:15];

    always @(negedge clk) begin
        if (rst) begin
            bus_if.ack = 1'b0;
            wcnt = 0;
        end else if (bus_if.ack) begin
            bus_if.ack = 1'b0;
        end else if (bus_if.req) begin
            wcnt++;
            if (wcnt == 3 && !(withhold && n_tx == hold_idx)) begin
                if (bus_if.wr) begin
                    mem[bus_if.addr[9:1]] = bus_if.wdata;
                end else if (bus_if.addr == 10'h000) begin
                    bus_if.rdata = mr_val;
                end else if (bus_if.addr == 10'h01A && corrupt) begin
                    bus_if.rdata = 16'h0165;
                end else begin
                    bus_if.rdata = mem[bus_if.addr[9:1]];
                end
                if (n_tx < 16) begin
                    log_wr[n_tx]    = bus_if.wr;
                    log_addr[n_tx]  = bus_if.addr;
                    log_wdata[n_tx] = bus_if.wdata;
                end
                n_tx++;
                bus_if.ack = 1'b1;
                wcnt = 0;
            end
        end else begin
            wcnt = 0;
        end
    end

    logic        exp_wr    [0:12];
    logic [9:0]  exp_addr  [0:12];
    logic [15:0] exp_wdata [0:12];

    task automatic pulse_start();
        n_tx = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!(ready || err) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_finished_in_time"}, (k < 400) ? 1 : 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_chip_rst_n"}, chip_rst_n, 0);
        check({tag, "_req"}, bus_if.req, 0);
        check({tag, "_wr"}, bus_if.wr, 0);
        check({tag, "_addr"}, bus_if.addr, 0);
        check({tag, "_wdata"}, bus_if.wdata, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_err_code"}, err_code, 0);
    endtask

    task automatic count_chip_low(input string tag);
        int k;
        k = 0;
        while (chip_rst_n == 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_chip_rst_low_cycles"}, k, 4);
    endtask

    initial begin
        int k;
        exp_wr[0]  = 0; exp_addr[0]  = 10'h000; exp_wdata[0]  = 16'h0000;
        exp_wr[1]  = 1; exp_addr[1]  = 10'h004; exp_wdata[1]  = 16'h0000;
        exp_wr[2]  = 1; exp_addr[2]  = 10'h008; exp_wdata[2]  = 16'h0008;
        exp_wr[3]  = 1; exp_addr[3]  = 10'h00A; exp_wdata[3]  = 16'hDC01;
        exp_wr[4]  = 1; exp_addr[4]  = 10'h00C; exp_wdata[4]  = 16'h0203;
        exp_wr[5]  = 1; exp_addr[5]  = 10'h010; exp_wdata[5]  = 16'hC0A8;
        exp_wr[6]  = 1; exp_addr[6]  = 10'h012; exp_wdata[6]  = 16'h0101;
        exp_wr[7]  = 1; exp_addr[7]  = 10'h014; exp_wdata[7]  = 16'hFFFF;
        exp_wr[8]  = 1; exp_addr[8]  = 10'h016; exp_wdata[8]  = 16'hFF00;
        exp_wr[9]  = 1; exp_addr[9]  = 10'h018; exp_wdata[9]  = 16'hC0A8;
        exp_wr[10] = 1; exp_addr[10] = 10'h01A; exp_wdata[10] = 16'h0164;
        exp_wr[11] = 0; exp_addr[11] = 10'h018; exp_wdata[11] = 16'h0000;
        exp_wr[12] = 0; exp_addr[12] = 10'h01A; exp_wdata[12] = 16'h0000;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;

        rst = 1'b1;
        start = 1'b0;
        bus_if.ack = 1'b0;
        bus_if.rdata = 16'h0000;
        mr_val = 16'hB800;
        corrupt = 1'b0;
        withhold = 1'b0;
        hold_idx = 0;
        wcnt = 0;
        n_tx = 0;

        // 1: reset values and power-up timing
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        count_chip_low("t1");
        k = 0;
        while (bus_if.req == 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t1_first_req_delay", k, 9);
        check("t1_first_addr", bus_if.addr, 10'h000);
        check("t1_first_wr", bus_if.wr, 0);

        // 2: full successful sequence
        wait_done("t2");
        check("t2_ready", ready, 1);
        check("t2_err", err, 0);
        check("t2_err_code", err_code, 0);
        check("t2_n_tx", n_tx, 13);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("t2_step%0d_wr", i), log_wr[i], exp_wr[i]);
            check($sformatf("t2_step%0d_addr", i), log_addr[i], exp_addr[i]);
            if (exp_wr[i]) check($sformatf("t2_step%0d_wdata", i), log_wdata[i], exp_wdata[i]);
        end

        // 3: bus-width mismatch
        mr_val = 16'h3800;
        pulse_start();
        wait_done("t3");
        check("t3_err", err, 1);
        check("t3_err_code", err_code, 1);
        check("t3_ready", ready, 0);
        repeat (20) @(negedge clk);
        check("t3_n_tx_after_idle", n_tx, 1);
        check("t3_req_idle", bus_if.req, 0);

        // 4: read-back mismatch, then restart to ready
        mr_val = 16'hB800;
        corrupt = 1'b1;
        pulse_start();
        wait_done("t4a");
        check("t4_err_code", err_code, 2);
        check("t4_ready", ready, 0);
        check("t4_n_tx", n_tx, 13);
        corrupt = 1'b0;
        pulse_start();
        check("t4_restart_chip_rst_n", chip_rst_n, 0);
        check("t4_restart_err_cleared", err, 0);
        check("t4_restart_code_cleared", err_code, 0);
        wait_done("t4b");
        check("t4_rerun_ready", ready, 1);
        check("t4_rerun_err_code", err_code, 0);
        check("t4_rerun_n_tx", n_tx, 13);

        // 5: ack withheld on step 3
        withhold = 1'b1;
        hold_idx = 3;
        pulse_start();
        k = 0;
        while (!(n_tx == 3 && bus_if.req == 1'b0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        while (bus_if.req == 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t5_reached_step3", (k < 200) ? 1 : 0, 1);
        check("t5_step3_addr", bus_if.addr, 10'h00A);
        k = 0;
        while (bus_if.req == 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t5_timeout_cycles", k, 16);
        check("t5_err", err, 1);
        check("t5_err_code", err_code, 3);
        check("t5_ready", ready, 0);
        withhold = 1'b0;

        // 6: reset while step 6 awaits ack
        pulse_start();
        k = 0;
        while (!(n_tx == 6 && bus_if.req == 1'b1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t6_reached_step6", (k < 200) ? 1 : 0, 1);
        check("t6_step6_addr", bus_if.addr, 10'h012);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6");
        rst = 1'b0;
        n_tx = 0;
        count_chip_low("t6");
        wait_done("t6");
        check("t6_ready", ready, 1);
        check("t6_n_tx", n_tx, 13);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
